// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// One 32-step shift-add (multiply) or restoring (divide) pass per operation,
// followed by a sign-fix/select cycle. BUSY stalls the pipeline meanwhile.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | waiting for START; result/write address held
//   S_CALC | one iteration per edge, 32 edges total
//   S_FIN  | sign fix + result select; DONE pulses on leaving this state
module muldiv_unit (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic        FLUSH,
   input  logic [2:0]  FUNCT3,
   input  logic [31:0] DATA1,
   input  logic [31:0] DATA2,
   input  logic [4:0]  DEST,
   output logic [31:0] RESULT,
   output logic [4:0]  WRITE_ADDR,
   output logic        WRITE_EN,
   output logic        DONE,
   output logic        BUSY
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [2:0]  f3_q, f3_d;
   logic [4:0]  dest_q, dest_d;
   logic        sign_a_q, sign_a_d;
   logic        sign_b_q, sign_b_d;
   logic        div0_q, div0_d;
   logic        ovf_q, ovf_d;
   // Multiply: acc = running product, opa = shifted multiplicand, opb = multiplier.
   // Divide:   acc = {remainder, quotient/dividend}, opb = divisor,
   //           opa[31:0] = raw dividend (returned as remainder on divide by zero).
   logic [63:0] acc_q, acc_d;
   logic [63:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  waddr_q, waddr_d;
   logic        done_q, done_d;

   logic        accept;
   logic        a_signed, b_signed;
   logic [31:0] a_mag, b_mag;
   logic [32:0] rem_sh;
   logic [31:0] rem_sub;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix, fin_res;

   // Next-state, datapath iteration and result selection.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      dest_d   = dest_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      div0_d   = div0_q;
      ovf_d    = ovf_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      waddr_d  = waddr_q;
      done_d   = 1'b0;

      // The FIN edge also takes a new request so back-to-back operations
      // complete every 33 edges without an idle bubble.
      accept   = START && !FLUSH && ((state_q == S_IDLE) || (state_q == S_FIN));
      a_signed = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) ||
                 (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
      b_signed = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
      a_mag    = (a_signed && DATA1[31]) ? -DATA1 : DATA1;
      b_mag    = (b_signed && DATA2[31]) ? -DATA2 : DATA2;

      rem_sh   = {acc_q[63:32], acc_q[31]};
      rem_sub  = rem_sh[31:0] - opb_q;

      prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
      quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[31:0] : acc_q[31:0];
      rem_fix  = sign_a_q ? -acc_q[63:32] : acc_q[63:32];
      if (div0_q) begin
         quot_fix = 32'hFFFF_FFFF;
         rem_fix  = opa_q[31:0];
      end
      if (ovf_q) begin
         quot_fix = 32'h8000_0000;
         rem_fix  = 32'h0000_0000;
      end
      case (f3_q)
         3'b000:                 fin_res = prod_fix[31:0];
         3'b001, 3'b010, 3'b011: fin_res = prod_fix[63:32];
         3'b100, 3'b101:         fin_res = quot_fix;
         default:                fin_res = rem_fix;
      endcase

      case (state_q)
         S_CALC: begin
            if (!f3_q[2]) begin
               acc_d = acc_q + (opb_q[0] ? opa_q : 64'd0);
               opa_d = opa_q << 1;
               opb_d = opb_q >> 1;
            end else if (rem_sh >= {1'b0, opb_q}) begin
               acc_d = {rem_sub, acc_q[30:0], 1'b1};
            end else begin
               acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            result_d = fin_res;
            waddr_d  = dest_q;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         state_d  = S_CALC;
         cnt_d    = 5'd0;
         f3_d     = FUNCT3;
         dest_d   = DEST;
         sign_a_d = a_signed && DATA1[31];
         sign_b_d = b_signed && DATA2[31];
         div0_d   = FUNCT3[2] && (DATA2 == 32'd0);
         ovf_d    = FUNCT3[2] && !FUNCT3[0] &&
                    (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
         opb_d    = b_mag;
         if (FUNCT3[2]) begin
            acc_d = {32'd0, a_mag};
            opa_d = {32'd0, DATA1};
         end else begin
            acc_d = 64'd0;
            opa_d = {32'd0, a_mag};
         end
      end

      if (FLUSH) begin
         state_d  = S_IDLE;
         done_d   = 1'b0;
         result_d = result_q;
         waddr_d  = waddr_q;
      end
   end

   // FSM and datapath registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         f3_q     <= 3'd0;
         dest_q   <= 5'd0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         acc_q    <= 64'd0;
         opa_q    <= 64'd0;
         opb_q    <= 32'd0;
         result_q <= 32'd0;
         waddr_q  <= 5'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         dest_q   <= dest_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         div0_q   <= div0_d;
         ovf_q    <= ovf_d;
         acc_q    <= acc_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         waddr_q  <= waddr_d;
         done_q   <= done_d;
      end
   end

   assign RESULT     = result_q;
   assign WRITE_ADDR = waddr_q;
   assign DONE       = done_q;
   assign BUSY       = (state_q != S_IDLE);
   assign WRITE_EN   = done_q && (waddr_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model of the RV32M operations.
module tb_muldiv_unit;

   logic        CLK, RESET, START, FLUSH;
   logic [2:0]  FUNCT3;
   logic [31:0] DATA1, DATA2;
   logic [4:0]  DEST;
   logic [31:0] RESULT;
   logic [4:0]  WRITE_ADDR;
   logic        WRITE_EN, DONE, BUSY;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_res = 32'd0;
   logic [4:0]  exp_wa  = 5'd0;

   muldiv_unit dut (
      .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH),
      .FUNCT3(FUNCT3), .DATA1(DATA1), .DATA2(DATA2), .DEST(DEST),
      .RESULT(RESULT), .WRITE_ADDR(WRITE_ADDR), .WRITE_EN(WRITE_EN),
      .DONE(DONE), .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // RV32M semantics computed with plain integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int          ia, ib;
      longint      sa, sb, pb, p;
      logic [63:0] up;
      ia = a; ib = b;
      sa = ia; sb = ib;
      pb = {32'd0, b};
      case (f)
         3'b000: begin p = sa * sb; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * pb; return p[63:32]; end
         3'b011: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // Drive a request so that it is sampled at the next posedge; returns 1ns after it.
   task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
      @(negedge CLK);
      FUNCT3 = f; DATA1 = a; DATA2 = b; DEST = d; START = 1'b1;
      @(posedge CLK); #1;
   endtask

   // Issue one operation and observe its completion (no comparisons here).
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                         output int de, output logic [31:0] r, output logic [4:0] wa,
                         output logic we, output bit bok);
      de = -1; r = 32'd0; wa = 5'd0; we = 1'b0; bok = 1'b1;
      drive_start(f, a, b, d);
      if (BUSY !== 1'b1) bok = 1'b0;
      @(negedge CLK);
      START = 1'b0;
      FUNCT3 = 3'($urandom); DATA1 = $urandom; DATA2 = $urandom; DEST = 5'($urandom);
      for (int e = 1; e <= 40; e++) begin
         @(posedge CLK); #1;
         if (DONE === 1'b1) begin
            de = e; r = RESULT; wa = WRITE_ADDR; we = WRITE_EN;
            if (BUSY !== 1'b0) bok = 1'b0;
            break;
         end else if (BUSY !== 1'b1) begin
            bok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
      FUNCT3 = 3'd0; DATA1 = 32'd0; DATA2 = 32'd0; DEST = 5'd0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      @(posedge CLK); #1;
      checks++; if (RESULT !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", RESULT); end
      checks++; if (WRITE_ADDR !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", WRITE_ADDR); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
      checks++; if (WRITE_EN !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", WRITE_EN); end
   endtask

   typedef struct packed {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [4:0]  d;
   } vec_t;

   task automatic test_directed();
      vec_t        tbl[13];
      int          de;
      logic [31:0] r;
      logic [4:0]  wa;
      logic        we;
      bit          bok;
      tbl[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd5};
      tbl[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 5'd6};
      tbl[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd7};
      tbl[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8};
      tbl[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 5'd9};
      tbl[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 5'd10};
      tbl[6]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 5'd11};
      tbl[7]  = '{3'b111, 32'd5,          32'd0,         32'd5,         5'd12};
      tbl[8]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 5'd13};
      tbl[9]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         5'd14};
      tbl[10] = '{3'b000, 32'd3,          32'd4,         32'd12,        5'd0};
      tbl[11] = '{3'b100, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 5'd1};
      tbl[12] = '{3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 5'd2};
      for (int i = 0; i < 13; i++) begin
         run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].d, de, r, wa, we, bok);
         checks++; if (de != 33) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 33", i, de); end
         checks++; if (!bok) begin errors++; $display("FAIL dir%0d_busy: got bad BUSY profile expected high edges 0..32, low at 33", i); end
         checks++; if (r !== tbl[i].res) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, r, tbl[i].res); end
         checks++; if (wa !== tbl[i].d) begin errors++; $display("FAIL dir%0d_waddr: got %0d expected %0d", i, wa, tbl[i].d); end
         checks++; if (we !== (tbl[i].d != 5'd0)) begin errors++; $display("FAIL dir%0d_wen: got %b expected %b", i, we, tbl[i].d != 5'd0); end
         exp_res = tbl[i].res; exp_wa = tbl[i].d;
      end
   endtask

   task automatic test_random();
      int          de;
      logic [31:0] r, a, b, m;
      logic [4:0]  wa, d;
      logic [2:0]  f;
      logic        we;
      bit          bok;
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom); a = pick(); b = pick(); d = 5'($urandom);
         m = model(f, a, b);
         run_op(f, a, b, d, de, r, wa, we, bok);
         checks++; if (de != 33 || !bok) begin errors++; $display("FAIL rnd%0d_timing: got done edge %0d busy_ok %0b expected 33 1", i, de, bok); end
         checks++; if (r !== m) begin errors++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h: got %h expected %h", i, f, a, b, r, m); end
         checks++; if (wa !== d || we !== (d != 5'd0)) begin errors++; $display("FAIL rnd%0d_wb: got addr %0d en %b expected %0d %b", i, wa, we, d, d != 5'd0); end
         exp_res = m; exp_wa = d;
      end
   endtask

   task automatic test_ignore_start();
      int          ndone = 0, first = -1;
      logic [31:0] r = 32'd0, a1, b1, m1;
      a1 = $urandom; b1 = $urandom; m1 = model(3'b011, a1, b1);
      drive_start(3'b011, a1, b1, 5'd17);
      for (int e = 1; e <= 70; e++) begin
         @(negedge CLK);
         START = (e == 10);
         if (e == 10) begin FUNCT3 = 3'b000; DATA1 = 32'd1; DATA2 = 32'd1; DEST = 5'd3; end
         @(posedge CLK); #1;
         if (DONE === 1'b1) begin
            ndone++;
            if (first < 0) begin first = e; r = RESULT; end
         end
      end
      checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_start_count: got %0d dones expected 1", ndone); end
      checks++; if (first != 33) begin errors++; $display("FAIL ignore_start_edge: got %0d expected 33", first); end
      checks++; if (r !== m1) begin errors++; $display("FAIL ignore_start_result: got %h expected %h", r, m1); end
      exp_res = m1; exp_wa = 5'd17;
   endtask

   task automatic test_back_to_back();
      int          edges[$];
      logic [31:0] res[$];
      logic [4:0]  was[$];
      logic [31:0] a1, b1, a2, b2, m1, m2;
      bit          consec = 1'b0;
      a1 = pick(); b1 = pick(); a2 = pick(); b2 = pick();
      m1 = model(3'b100, a1, b1);
      m2 = model(3'b001, a2, b2);
      drive_start(3'b100, a1, b1, 5'd21);
      for (int e = 1; e <= 80; e++) begin
         @(negedge CLK);
         START = (e == 33);
         if (e == 33) begin FUNCT3 = 3'b001; DATA1 = a2; DATA2 = b2; DEST = 5'd22; end
         @(posedge CLK); #1;
         if (DONE === 1'b1) begin
            if (edges.size() > 0 && edges[edges.size()-1] == e - 1) consec = 1'b1;
            edges.push_back(e); res.push_back(RESULT); was.push_back(WRITE_ADDR);
         end
      end
      checks++; if (edges.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d dones expected 2", edges.size()); end
      checks++; if (consec) begin errors++; $display("FAIL b2b_consecutive_done: got 1 expected 0"); end
      if (edges.size() >= 2) begin
         checks++; if (edges[0] != 33 || edges[1] != 66) begin errors++; $display("FAIL b2b_edges: got %0d,%0d expected 33,66", edges[0], edges[1]); end
         checks++; if (res[0] !== m1 || was[0] !== 5'd21) begin errors++; $display("FAIL b2b_first: got %h@%0d expected %h@21", res[0], was[0], m1); end
         checks++; if (res[1] !== m2 || was[1] !== 5'd22) begin errors++; $display("FAIL b2b_second: got %h@%0d expected %h@22", res[1], was[1], m2); end
      end
      exp_res = m2; exp_wa = 5'd22;
   endtask

   task automatic test_flush();
      int ndone = 0;
      bit idle_ok = 1'b1;
      drive_start(3'b000, $urandom, $urandom, 5'd9);
      for (int e = 1; e <= 40; e++) begin
         @(negedge CLK);
         START = 1'b0;
         FLUSH = (e == 12);
         @(posedge CLK); #1;
         if (e == 11) begin
            checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", BUSY); end
         end
         if (e == 12) begin
            checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b expected 0", BUSY); end
         end
         if (DONE === 1'b1) ndone++;
      end
      FLUSH = 1'b0;
      checks++; if (ndone != 0) begin errors++; $display("FAIL flush_no_done: got %0d dones expected 0", ndone); end
      checks++; if (RESULT !== exp_res || WRITE_ADDR !== exp_wa) begin errors++; $display("FAIL flush_hold: got %h@%0d expected %h@%0d", RESULT, WRITE_ADDR, exp_res, exp_wa); end
      @(negedge CLK);
      FLUSH = 1'b1; START = 1'b1; FUNCT3 = 3'b101; DATA1 = 32'd100; DATA2 = 32'd7; DEST = 5'd4;
      @(posedge CLK); #1;
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL flush_beats_start: got BUSY %b expected 0", BUSY); end
      @(negedge CLK);
      FLUSH = 1'b0; START = 1'b0;
      for (int e = 0; e < 40; e++) begin
         @(posedge CLK); #1;
         if (BUSY !== 1'b0 || DONE !== 1'b0) idle_ok = 1'b0;
      end
      checks++; if (!idle_ok) begin errors++; $display("FAIL flush_start_idle: got activity expected BUSY=0 DONE=0 throughout"); end
   endtask

   task automatic test_reset_mid();
      int          de;
      logic [31:0] r, a, b, m;
      logic [4:0]  wa;
      logic        we;
      bit          bok;
      drive_start(3'b110, $urandom, $urandom_range(1, 1000), 5'd30);
      @(negedge CLK);
      START = 1'b0;
      repeat (15) @(posedge CLK);
      #4;
      RESET = 1'b1;
      #1;
      checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || WRITE_EN !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy %b done %b wen %b expected 0 0 0", BUSY, DONE, WRITE_EN); end
      checks++; if (RESULT !== 32'd0 || WRITE_ADDR !== 5'd0) begin errors++; $display("FAIL rstmid_data: got %h@%0d expected 00000000@0", RESULT, WRITE_ADDR); end
      @(negedge CLK);
      RESET = 1'b0;
      a = pick(); b = pick(); m = model(3'b111, a, b);
      run_op(3'b111, a, b, 5'd19, de, r, wa, we, bok);
      checks++; if (de != 33 || !bok) begin errors++; $display("FAIL rstmid_after_timing: got edge %0d busy_ok %0b expected 33 1", de, bok); end
      checks++; if (r !== m || wa !== 5'd19 || we !== 1'b1) begin errors++; $display("FAIL rstmid_after_result: got %h@%0d en %b expected %h@19 en 1", r, wa, we, m); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
